mux_sequencer: RTL and testbench

Sequences the eight LED-column multiplex lines (`fpga_mul_*`) in step with `driver_controller`. After each position sync it walks the multiplex slots 0..NB_MUX-1 and enables one slot at a time, one-hot. A slot advances when the driver signals that the slot's data has been latched. Between slots it inserts a blanking gap with all lines off, to prevent ghosting. It also publishes the slot index to the framebuffer read logic and flags syncs that arrive before a slice has completed.

---
 rtl/mux_sequencer_if.sv | 40 ++++
 rtl/mux_sequencer.sv | 142 ++++++++++++++
 tb/tb_mux_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mux_sequencer_if.sv
// Handshake bundle between the LED driver controller and the multiplex sequencer.
// The controller side drives the qualifiers and pulses; the sequencer drives the column enables.
interface mux_sequencer_if #(
    parameter int NB_MUX = 8,
    parameter int MUX_W  = $clog2(NB_MUX)
);
    logic              clk_enable;
    logic              driver_ready;
    logic              position_sync;
    logic              mux_done;
    logic [NB_MUX-1:0] mux_out;
    logic [MUX_W-1:0]  mux_idx;
    logic              blanking;
    logic              slice_done;
    logic              overrun;

    modport master (
        output clk_enable,
        output driver_ready,
        output position_sync,
        output mux_done,
        input  mux_out,
        input  mux_idx,
        input  blanking,
        input  slice_done,
        input  overrun
    );

    modport slave (
        input  clk_enable,
        input  driver_ready,
        input  position_sync,
        input  mux_done,
        output mux_out,
        output mux_idx,
        output blanking,
        output slice_done,
        output overrun
    );
endinterface

// File: rtl/mux_sequencer.sv
// Walks the LED-column multiplex lines one-hot after each position sync, with a
// blanking gap between slots; reports slice completion and mid-slice resyncs.
module mux_sequencer #(
    parameter int NB_MUX       = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int MUX_W        = $clog2(NB_MUX)
) (
    input  logic             clk,
    input  logic             nrst,
    mux_sequencer_if.slave   io_bus
);
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_ON,
        S_BLANK
    } state_t;

    state_t            r_state;
    logic [NB_MUX-1:0] r_mux_out;
    logic [MUX_W-1:0]  r_mux_idx;
    logic              r_blanking;
    logic              r_slice_done;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;

    state_t            w_state_nxt;
    logic [NB_MUX-1:0] w_mux_out_nxt;
    logic [MUX_W-1:0]  w_mux_idx_nxt;
    logic              w_slice_done_nxt;
    logic              w_overrun_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last_nxt;

    logic              w_is_last_slot;
    logic [MUX_W-1:0]  w_idx_inc;
    logic              w_restart;

    assign w_is_last_slot = (r_mux_idx == MUX_W'(NB_MUX - 1));
    assign w_idx_inc      = w_is_last_slot ? '0 : r_mux_idx + MUX_W'(1);

    // A sync that lands mid-slice abandons the slice and restarts it from slot 0.
    assign w_restart = io_bus.driver_ready && io_bus.position_sync &&
                       ((r_state == S_ON) || (r_state == S_BLANK));

    always_comb begin
        w_state_nxt      = r_state;
        w_mux_out_nxt    = r_mux_out;
        w_mux_idx_nxt    = r_mux_idx;
        w_slice_done_nxt = 1'b0;
        w_overrun_nxt    = r_overrun;
        w_cnt_nxt        = r_cnt;
        w_last_nxt       = r_last;

        if (!io_bus.driver_ready) begin
            w_state_nxt   = S_IDLE;
            w_mux_out_nxt = '0;
            w_mux_idx_nxt = '0;
        end else if (w_restart) begin
            w_state_nxt   = S_BLANK;
            w_mux_out_nxt = '0;
            w_mux_idx_nxt = '0;
            w_overrun_nxt = 1'b1;
            w_cnt_nxt     = CNT_W'(BLANK_CYCLES);
            w_last_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_SYNC;
                end
                S_WAIT_SYNC: begin
                    if (io_bus.position_sync) begin
                        w_state_nxt   = S_ON;
                        w_mux_idx_nxt = '0;
                        w_mux_out_nxt = NB_MUX'(1);
                    end
                end
                S_ON: begin
                    if (io_bus.mux_done) begin
                        w_state_nxt   = S_BLANK;
                        w_mux_out_nxt = '0;
                        w_mux_idx_nxt = w_idx_inc;
                        w_cnt_nxt     = CNT_W'(BLANK_CYCLES);
                        w_last_nxt    = w_is_last_slot;
                    end
                end
                S_BLANK: begin
                    if (io_bus.clk_enable) begin
                        if (r_cnt == CNT_W'(1)) begin
                            if (r_last) begin
                                w_state_nxt      = S_WAIT_SYNC;
                                w_slice_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt   = S_ON;
                                w_mux_out_nxt = NB_MUX'(1) << r_mux_idx;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_mux_out_nxt = '0;
                    w_mux_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_mux_out    <= '0;
            r_mux_idx    <= '0;
            r_blanking   <= 1'b1;
            r_slice_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mux_out    <= w_mux_out_nxt;
            r_mux_idx    <= w_mux_idx_nxt;
            r_blanking   <= (w_mux_out_nxt == '0);
            r_slice_done <= w_slice_done_nxt;
            r_overrun    <= w_overrun_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last       <= w_last_nxt;
        end
    end

    assign io_bus.mux_out    = r_mux_out;
    assign io_bus.mux_idx    = r_mux_idx;
    assign io_bus.blanking   = r_blanking;
    assign io_bus.slice_done = r_slice_done;
    assign io_bus.overrun    = r_overrun;

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed bench for mux_sequencer (NB_MUX = 8, BLANK_CYCLES = 4): a vector table
// for reset/IDLE/first slots, plus hand-written multi-cycle slice sequences.
module tb_mux_sequencer;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mux_sequencer_if #(.NB_MUX(8)) bus();

    mux_sequencer #(.NB_MUX(8), .BLANK_CYCLES(4)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .io_bus(bus)
    );

    typedef struct packed {
        logic       nrst;
        logic       rdy;
        logic       en;
        logic       sync;
        logic       done;
        logic [7:0] eo;
        logic [2:0] ei;
        logic       esd;
        logic       eov;
    } vec_t;

    vec_t vecs [14];

    task automatic cyc(input logic r, input logic e, input logic s, input logic d);
        bus.driver_ready  = r;
        bus.clk_enable    = e;
        bus.position_sync = s;
        bus.mux_done      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] eo, input logic [2:0] ei,
                       input logic esd, input logic eov);
        logic [13:0] exp_v;
        logic [13:0] act_v;
        exp_v = {eo, ei, (eo == 8'h00), esd, eov};
        act_v = {bus.mux_out, bus.mux_idx, bus.blanking, bus.slice_done, bus.overrun};
        n_chk++;
        if (act_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s (check %0d): got out=%h idx=%0d blank=%b sd=%b ovr=%b, want out=%h idx=%0d blank=%b sd=%b ovr=%b",
                     nm, n_chk, bus.mux_out, bus.mux_idx, bus.blanking, bus.slice_done, bus.overrun,
                     eo, ei, (eo == 8'h00), esd, eov);
        end
    endtask

    // Blanking gap after slot s finished; with half set, clk_enable is high every second clk.
    task automatic gap(input int s, input bit half, input logic ov);
        int n;
        n = half ? 8 : 4;
        for (int k = 1; k <= n; k++) begin
            cyc(1'b1, half ? logic'(k % 2 == 0) : 1'b1, 1'b0, 1'b0);
            if (k < n) begin
                chk("gap", 8'h00, 3'((s + 1) % 8), 1'b0, ov);
            end else if (s < 7) begin
                chk("next_slot", 8'(1 << (s + 1)), 3'(s + 1), 1'b0, ov);
            end else begin
                chk("slice_done", 8'h00, 3'd0, 1'b1, ov);
                cyc(1'b1, 1'b1, 1'b0, 1'b0);
                chk("slice_done_clr", 8'h00, 3'd0, 1'b0, ov);
            end
        end
    endtask

    // Runs slots first..last, each starting with its one-hot already visible; mux_done 6 clk after enable.
    task automatic walk(input int first, input int last, input bit half, input logic ov);
        for (int s = first; s <= last; s++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(1'b1, 1'b1, 1'b0, 1'b0);
                chk("slot_on", 8'(1 << s), 3'(s), 1'b0, ov);
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            chk("slot_done", 8'h00, 3'((s + 1) % 8), 1'b0, ov);
            gap(s, half, ov);
        end
    endtask

    initial begin
        bus.driver_ready  = 1'b0;
        bus.clk_enable    = 1'b0;
        bus.position_sync = 1'b0;
        bus.mux_done      = 1'b0;

        //          nrst  rdy   en    sync  done  out    idx   sd    ovr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            nrst = vecs[i].nrst;
            cyc(vecs[i].rdy, vecs[i].en, vecs[i].sync, vecs[i].done);
            chk($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ei, vecs[i].esd, vecs[i].eov);
        end

        // Full slice with clk_enable always high, then one with clk_enable every second clk.
        nrst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("wait_sync", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("first_enable", 8'h01, 3'd0, 1'b0, 1'b0);
        walk(0, 7, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("resync", 8'h01, 3'd0, 1'b0, 1'b0);
        walk(0, 7, 1'b1, 1'b0);

        // Sync while slot 3 is ON.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovr_start", 8'h01, 3'd0, 1'b0, 1'b0);
        walk(0, 2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("slot3_on", 8'h08, 3'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovr_set", 8'h00, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (k < 4) chk("ovr_gap", 8'h00, 3'd0, 1'b0, 1'b1);
            else       chk("ovr_restart", 8'h01, 3'd0, 1'b0, 1'b1);
        end
        walk(0, 7, 1'b0, 1'b1);

        // mux_done and position_sync together on slot 5.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("both_start", 8'h01, 3'd0, 1'b0, 1'b1);
        walk(0, 4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("slot5_on", 8'h20, 3'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("both_sync_wins", 8'h00, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (k < 4) chk("both_gap", 8'h00, 3'd0, 1'b0, 1'b1);
            else       chk("both_restart", 8'h01, 3'd0, 1'b0, 1'b1);
        end
        nrst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovr_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // driver_ready dropped during the blank after slot 2.
        nrst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("drop_wait", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("drop_start", 8'h01, 3'd0, 1'b0, 1'b0);
        walk(0, 1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("slot2_done", 8'h00, 3'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("slot2_blank", 8'h00, 3'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("drop_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_sync_ignored", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rearm_wait", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("wait_done_ignored1", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("wait_done_ignored2", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rearm_start", 8'h01, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rearm_hold", 8'h01, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
